// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Multi-cycle integer execute unit for the execute stage. It takes the 4-bit
// Operation code from the ALU control decoder and applies it to two WIDTH-bit
// operands. AND, OR, ADD and SUB finish in one cycle. SLL is bit-serial and
// shifts one position per cycle. Valid/ready handshakes on both sides let a
// stalled writeback stage back-pressure the unit.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   request carries a valid operation
//   in_ready   unit can accept a request this cycle (only while idle)
//   Operation  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLL
//   a          operand A (rs1)
//   b          operand B (rs2 or immediate); SLL uses b[SHW-1:0] as amount
//   out_valid  Result and flags are valid
//   out_ready  consumer accepts the result this cycle
//   Result     operation result
//   Zero       Result == 0
//   Less       signed compare a < b of the captured operands (for BGE)
//   Illegal    Operation was not one of the five legal codes
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 64,
  parameter int SHW   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Less,
  output logic             Illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;

  localparam logic [SHW-1:0] COUNT_ONE = SHW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } stateT;

  stateT            state;
  logic [WIDTH-1:0] shiftAcc;
  logic [SHW-1:0]   shiftCount;
  logic [SHW-1:0]   shiftAmount;
  logic [WIDTH-1:0] quickResult;
  logic             opLegal;
  logic             startShift;

  // The handshake flags come straight from the state register. A request is
  // only accepted while idle. A result is only presented while in DONE.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Zero always follows the held Result. Reset clears Result, so Zero reads 1
  // after reset.
  assign Zero = (Result == '0);

  // Decode the incoming request. This block computes the single-cycle result
  // for every code except a nonzero shift. An SLL with a zero amount passes
  // a through unchanged, so it takes the fast path and skips the serial
  // shifter. Illegal codes produce a zero result.
  always_comb begin
    shiftAmount = b[SHW-1:0];
    quickResult = '0;
    opLegal     = 1'b1;
    startShift  = 1'b0;
    case (Operation)
      OP_AND: quickResult = a & b;
      OP_OR:  quickResult = a | b;
      OP_ADD: quickResult = a + b;
      OP_SUB: quickResult = a - b;
      OP_SLL: begin
        quickResult = a;
        startShift  = (shiftAmount != '0);
      end
      default: opLegal = 1'b0;
    endcase
  end

  // Main control FSM. Reset wins over everything, including an in-flight
  // shift or a stalled result. On acceptance the block captures the operand
  // compare and the legality flag right away, so later input changes have no
  // effect. A nonzero shift loads the accumulator and the counter. Each SHIFT
  // cycle moves the accumulator left by one. When the counter is about to
  // reach zero, the final shifted value goes straight into Result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      Result     <= '0;
      Less       <= 1'b0;
      Illegal    <= 1'b0;
      shiftAcc   <= '0;
      shiftCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            Less    <= ($signed(a) < $signed(b));
            Illegal <= ~opLegal;
            if (startShift) begin
              shiftAcc   <= a;
              shiftCount <= shiftAmount;
              state      <= SHIFT;
            end else begin
              Result <= quickResult;
              state  <= DONE;
            end
          end
        end
        SHIFT: begin
          shiftAcc   <= shiftAcc << 1;
          shiftCount <= shiftCount - COUNT_ONE;
          if (shiftCount == COUNT_ONE) begin
            Result <= shiftAcc << 1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
